// File: rtl/adder_seq_arbiter.sv
// Two-requester serial adder: one nibble per clock through a shared 4-bit adder,
// round-robin arbitration, valid/ready on both sides.

module four_bit_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       carry_out
);
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {4'b0, cin};
endmodule

module adder_seq_arbiter #(
    parameter int N_NIBBLES = 4,
    localparam int W = 4 * N_NIBBLES
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_req0_valid,
    output logic         o_req0_ready,
    input  logic [W-1:0] i_req0_op1,
    input  logic [W-1:0] i_req0_op2,
    input  logic         i_req0_cin,
    input  logic         i_req1_valid,
    output logic         o_req1_ready,
    input  logic [W-1:0] i_req1_op1,
    input  logic [W-1:0] i_req1_op2,
    input  logic         i_req1_cin,
    output logic         o_res_valid,
    input  logic         i_res_ready,
    output logic [W-1:0] o_res_sum,
    output logic         o_res_cout,
    output logic         o_res_id
);
    localparam int CW = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(N_NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                     state;
    logic [N_NIBBLES-1:0][3:0]  op1_q;
    logic [N_NIBBLES-1:0][3:0]  op2_q;
    logic [N_NIBBLES-1:0][3:0]  sum_q;
    logic [N_NIBBLES-1:0][3:0]  sum_nx;
    logic                       carry_q;
    logic [CW-1:0]              cnt;
    logic                       last_id;
    logic                       id_q;
    logic                       grant0;
    logic                       grant1;
    logic [3:0]                 add_sum;
    logic                       add_co;

    // Both valid: serve whoever was not served last.
    assign grant0 = i_req0_valid && (!i_req1_valid || last_id);
    assign grant1 = i_req1_valid && (!i_req0_valid || !last_id);

    assign o_req0_ready = (state == IDLE) && grant0;
    assign o_req1_ready = (state == IDLE) && grant1;

    four_bit_adder u_add (
        .a         (op1_q[cnt]),
        .b         (op2_q[cnt]),
        .cin       (carry_q),
        .sum       (add_sum),
        .carry_out (add_co)
    );

    always_comb begin
        sum_nx      = sum_q;
        sum_nx[cnt] = add_sum;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            o_res_valid <= 1'b0;
            o_res_sum   <= '0;
            o_res_cout  <= 1'b0;
            o_res_id    <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt         <= '0;
            last_id     <= 1'b1;
            id_q        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (o_req0_ready) begin
                        op1_q   <= i_req0_op1;
                        op2_q   <= i_req0_op2;
                        carry_q <= i_req0_cin;
                        id_q    <= 1'b0;
                        last_id <= 1'b0;
                        cnt     <= '0;
                        state   <= CALC;
                    end else if (o_req1_ready) begin
                        op1_q   <= i_req1_op1;
                        op2_q   <= i_req1_op2;
                        carry_q <= i_req1_cin;
                        id_q    <= 1'b1;
                        last_id <= 1'b1;
                        cnt     <= '0;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    sum_q   <= sum_nx;
                    carry_q <= add_co;
                    cnt     <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state       <= DONE;
                        o_res_valid <= 1'b1;
                        o_res_sum   <= sum_nx;
                        o_res_cout  <= add_co;
                        o_res_id    <= id_q;
                    end
                end
                DONE: begin
                    if (i_res_ready) begin
                        o_res_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_seq_arbiter.sv
// Bench for adder_seq_arbiter: transaction-level model, per-cycle compare,
// directed corner cases then randomized traffic with backpressure.

module tb_adder_seq_arbiter;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         v0 = 1'b0, v1 = 1'b0, rr = 1'b0;
    logic [W-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic         c0 = 1'b0, c1 = 1'b0;
    logic         rdy0, rdy1, res_valid, res_cout, res_id;
    logic [W-1:0] res_sum;

    int checks = 0;
    int failures = 0;

    bit         m_busy, m_valid, m_last, m_id, m_pid;
    int         m_wait;
    logic [W-1:0] m_sum;
    logic       m_cout;
    logic [W:0] m_pend;
    bit         acc0, acc1;
    bit         pend0, pend1;

    always #5 clk = ~clk;

    adder_seq_arbiter #(.N_NIBBLES(N)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(v0), .o_req0_ready(rdy0),
        .i_req0_op1(a0), .i_req0_op2(b0), .i_req0_cin(c0),
        .i_req1_valid(v1), .o_req1_ready(rdy1),
        .i_req1_op1(a1), .i_req1_op2(b1), .i_req1_cin(c1),
        .o_res_valid(res_valid), .i_res_ready(rr),
        .o_res_sum(res_sum), .o_res_cout(res_cout), .o_res_id(res_id)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_valid = 0; m_last = 1; m_id = 0; m_pid = 0;
        m_wait = 0; m_sum = '0; m_cout = 0; m_pend = '0;
        acc0 = 0; acc1 = 0;
    endtask

    // Called just after a falling edge with inputs already set.
    task automatic cycle();
        bit er0, er1;
        #1;
        er0 = !m_busy && v0 && (!v1 || m_last);
        er1 = !m_busy && v1 && (!v0 || !m_last);
        chk("ready0", 32'(rdy0), 32'(er0));
        chk("ready1", 32'(rdy1), 32'(er1));
        chk("res_valid", 32'(res_valid), 32'(m_valid));
        chk("res_sum", 32'(res_sum), 32'(m_sum));
        chk("res_cout", 32'(res_cout), 32'(m_cout));
        chk("res_id", 32'(res_id), 32'(m_id));
        @(posedge clk);
        acc0 = 0; acc1 = 0;
        if (!m_busy) begin
            if (er0) begin
                m_busy = 1; m_wait = N; m_pid = 0; m_last = 0; acc0 = 1;
                m_pend = {1'b0, a0} + {1'b0, b0} + (W+1)'(c0);
            end else if (er1) begin
                m_busy = 1; m_wait = N; m_pid = 1; m_last = 1; acc1 = 1;
                m_pend = {1'b0, a1} + {1'b0, b1} + (W+1)'(c1);
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1;
                {m_cout, m_sum} = m_pend;
                m_id = m_pid;
            end
        end else if (rr) begin
            m_valid = 0;
            m_busy = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; v0 = 0; v1 = 0; rr = 0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    // One directed operation with literal result and latency checks.
    task automatic run_op(input bit id, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic c,
                          input logic [W-1:0] es, input logic ec);
        int lat;
        bit got;
        lat = -1; got = 0;
        v0 = 0; v1 = 0; rr = 1;
        if (id) begin v1 = 1; a1 = a; b1 = b; c1 = c; end
        else begin v0 = 1; a0 = a; b0 = b; c0 = c; end
        for (int i = 0; i < 30 && !got; i++) begin
            cycle();
            if (lat >= 0) lat++;
            if (acc0 || acc1) begin v0 = 0; v1 = 0; lat = 0; end
            if (res_valid) begin
                got = 1;
                chk("lit_sum", 32'(res_sum), 32'(es));
                chk("lit_cout", 32'(res_cout), 32'(ec));
                chk("lit_id", 32'(res_id), 32'(id));
                chk("latency", 32'(lat), 32'(N));
            end
        end
        if (!got) chk("op_timeout", 32'd0, 32'd1);
        cycle();
    endtask

    initial begin
        int order[$];
        int accepts;
        int guard;
        model_reset();
        #1;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_sum", 32'(res_sum), 32'd0);
        do_reset();

        run_op(0, 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
        run_op(1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op(0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
        run_op(1, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);

        // Round-robin from reset with both requesters always valid.
        do_reset();
        rr = 1;
        v0 = 1; a0 = 16'h1111; b0 = 16'h0101; c0 = 0;
        v1 = 1; a1 = 16'h8000; b1 = 16'h8000; c1 = 1;
        for (int i = 0; i < 100 && order.size() < 4; i++) begin
            cycle();
            if (acc0) begin order.push_back(0); a0 = a0 + 16'h0203; end
            if (acc1) begin order.push_back(1); b1 = b1 ^ 16'h0F0F; end
        end
        if (order.size() < 4) chk("rr_timeout", 32'(order.size()), 32'd4);
        else for (int i = 0; i < 4; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));
        v0 = 0; v1 = 0;
        for (int i = 0; i < 12; i++) cycle();

        // Backpressure: result held while consumer stalls.
        rr = 0; v0 = 1; a0 = 16'hABCD; b0 = 16'h1357; c0 = 1;
        guard = 0;
        while (!res_valid && guard < 30) begin
            cycle();
            if (acc0) begin v0 = 0; v1 = 1; a1 = 16'h0F0F; b1 = 16'h00F0; end
            guard++;
        end
        if (!res_valid) chk("bp_timeout", 32'd0, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_sum", 32'(res_sum), 32'h0000BF25);
        end
        v1 = 0; rr = 1;
        cycle();
        chk("bp_drop", 32'(res_valid), 32'd0);

        // Asynchronous reset in the second CALC cycle.
        v0 = 1; a0 = 16'h0F00; b0 = 16'h0100; c0 = 0;
        guard = 0;
        while (!acc0 && guard < 30) begin cycle(); guard++; end
        if (!acc0) chk("rst_acc_timeout", 32'd0, 32'd1);
        v0 = 0;
        cycle();
        rst = 1;
        #1;
        chk("arst_sum", 32'(res_sum), 32'd0);
        chk("arst_valid", 32'(res_valid), 32'd0);
        chk("arst_cout", 32'(res_cout), 32'd0);
        chk("arst_id", 32'(res_id), 32'd0);
        model_reset();
        v0 = 1; a0 = 16'h2222; b0 = 16'h3333; c0 = 1;
        v1 = 1; a1 = 16'h4444; b1 = 16'h5555; c1 = 0;
        @(negedge clk);
        rst = 0;
        #1;
        chk("arst_grant0", 32'(rdy0), 32'd1);
        chk("arst_grant1", 32'(rdy1), 32'd0);
        pend0 = 1; pend1 = 1;

        // Randomized traffic on both requesters with random backpressure.
        accepts = 0;
        for (int i = 0; i < 60000 && accepts < 1000; i++) begin
            if (!pend0 && $urandom_range(0, 1) == 1) begin
                pend0 = 1; a0 = W'($urandom); b0 = W'($urandom);
                c0 = 1'($urandom);
            end
            if (!pend1 && $urandom_range(0, 1) == 1) begin
                pend1 = 1; a1 = W'($urandom); b1 = W'($urandom);
                c1 = 1'($urandom);
            end
            v0 = pend0; v1 = pend1;
            rr = ($urandom_range(0, 3) != 0);
            cycle();
            if (acc0) begin pend0 = 0; accepts++; end
            if (acc1) begin pend1 = 0; accepts++; end
        end
        chk("rand_count", 32'(accepts >= 1000), 32'd1);
        v0 = 0; v1 = 0; rr = 1;
        for (int i = 0; i < 2 * N + 4; i++) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
